// File: rtl/aes_round_ctrl.sv
// AES round sequencer: steps the SubBytes/ShiftRows/MixColumns/AddRoundKey enables
// for the round count selected by the key size, with a one-cycle done pulse.
module aes_round_ctrl #(
  parameter int unsigned NR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      key_size_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            init_ark_en_o,
  output logic            sbox_en_o,
  output logic            shiftrows_en_o,
  output logic            mixcolumns_en_o,
  output logic            addrndkey_en_o,
  output logic [NR_W-1:0] round_o,
  output logic            last_round_o
);

  localparam logic [NR_W-1:0] Nr128 = NR_W'(10);
  localparam logic [NR_W-1:0] Nr192 = NR_W'(12);
  localparam logic [NR_W-1:0] Nr256 = NR_W'(14);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StInitArk = 3'd1,
    StSub     = 3'd2,
    StShift   = 3'd3,
    StMix     = 3'd4,
    StArk     = 3'd5,
    StDone    = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [NR_W-1:0] round_q, round_d;
  logic [NR_W-1:0] nr_q, nr_d;
  logic            is_last;
  logic [NR_W-1:0] round_inc;

  logic busy_q, done_q, init_ark_q, sbox_q, shift_q, mix_q, ark_q, last_q;
  logic busy_d, done_d, init_ark_d, sbox_d, shift_d, mix_d, ark_d, last_d;

  assign is_last   = (round_q == nr_q);
  // Saturate at Nr so the index can never run past the final round or wrap.
  assign round_inc = (round_q < nr_q) ? round_q + NR_W'(1) : round_q;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    nr_d    = nr_q;
    case (state_q)
      StIdle: begin
        round_d = '0;
        if (start_i) begin
          state_d = StInitArk;
          case (key_size_i)
            2'b01:   nr_d = Nr192;
            2'b10:   nr_d = Nr256;
            default: nr_d = Nr128;
          endcase
        end
      end
      StInitArk: begin
        state_d = StSub;
        round_d = round_inc;
      end
      StSub: begin
        state_d = StShift;
      end
      StShift: begin
        state_d = is_last ? StArk : StMix;
      end
      StMix: begin
        state_d = StArk;
      end
      StArk: begin
        if (is_last) begin
          state_d = StDone;
        end else begin
          state_d = StSub;
          round_d = round_inc;
        end
      end
      StDone: begin
        state_d = StIdle;
        round_d = '0;
      end
      default: begin
        state_d = StIdle;
        round_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly.
  always_comb begin
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    init_ark_d = (state_d == StInitArk);
    sbox_d     = (state_d == StSub);
    shift_d    = (state_d == StShift);
    mix_d      = (state_d == StMix);
    ark_d      = (state_d == StArk);
    last_d     = (state_d != StIdle) && (round_d == nr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      round_q    <= '0;
      nr_q       <= Nr128;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      init_ark_q <= 1'b0;
      sbox_q     <= 1'b0;
      shift_q    <= 1'b0;
      mix_q      <= 1'b0;
      ark_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      nr_q       <= nr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      init_ark_q <= init_ark_d;
      sbox_q     <= sbox_d;
      shift_q    <= shift_d;
      mix_q      <= mix_d;
      ark_q      <= ark_d;
      last_q     <= last_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign init_ark_en_o   = init_ark_q;
  assign sbox_en_o       = sbox_q;
  assign shiftrows_en_o  = shift_q;
  assign mixcolumns_en_o = mix_q;
  assign addrndkey_en_o  = ark_q;
  assign round_o         = round_q;
  assign last_round_o    = last_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: timing-formula model per cycle, done-cycle scoreboard,
// per-key-size vector table and an AES-128 datapath driven by the enables.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] key_size;
  logic       busy_o, done_o, init_o, sbox_o, shift_o, mix_o, ark_o, last_o;
  logic [3:0] round_o;

  aes_round_ctrl #(.NR_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start),
    .key_size_i     (key_size),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .init_ark_en_o  (init_o),
    .sbox_en_o      (sbox_o),
    .shiftrows_en_o (shift_o),
    .mixcolumns_en_o(mix_o),
    .addrndkey_en_o (ark_o),
    .round_o        (round_o),
    .last_round_o   (last_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] ks;
    int         done_t;
    int         n_sbox;
    int         n_shift;
    int         n_mix;
    int         n_ark;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  bit m_act    = 0;
  int m_s      = 0;
  int m_nr     = 10;
  int done_q[$];
  int last_done_e = -1;
  int c_init, c_sbox, c_shift, c_mix, c_ark;
  logic [7:0]   sb [256];
  logic [127:0] rk [11];
  logic [127:0] dp;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic check_blk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, aa = a, bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] calc_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb[gb(s, i)];
    return r;
  endfunction

  // Byte k = 4*col + row; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) r[127-8*(4*c+w) -: 8] = gb(s, 4*((c+w)%4)+w);
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      r[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return r;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One clock: predict acceptance, clock, then compare outputs against the timing formula.
  task automatic tick();
    int e, t, r, p, exp_round;
    logic [7:0] ev;
    if (rst_n && start && (!m_act || (edge_cnt - m_s) >= 4*m_nr + 2)) begin
      m_act = 1;
      m_s   = edge_cnt;
      m_nr  = (key_size == 2'b01) ? 12 : (key_size == 2'b10) ? 14 : 10;
      done_q.push_back(edge_cnt + 4*m_nr);
    end
    e = edge_cnt;
    @(posedge clk);
    edge_cnt++;
    #1;
    ev = 8'h00;
    exp_round = 0;
    t = e - m_s + 1;
    if (m_act && t > 4*m_nr + 1) m_act = 0;
    if (m_act && rst_n) begin
      ev[7] = 1'b1;
      if (t == 1) ev[5] = 1'b1;
      else if (t == 4*m_nr + 1) begin
        ev[6] = 1'b1;
        exp_round = m_nr;
      end else begin
        r = (t - 2) / 4 + 1;
        p = (t - 2) % 4;
        exp_round = r;
        if (p == 0) ev[4] = 1'b1;
        else if (p == 1) ev[3] = 1'b1;
        else if (p == 2 && r < m_nr) ev[2] = 1'b1;
        else ev[1] = 1'b1;
      end
      ev[0] = (exp_round == m_nr);
    end
    check_int("outputs{busy,done,init,sbox,shift,mix,ark,last}",
              {24'd0, busy_o, done_o, init_o, sbox_o, shift_o, mix_o, ark_o, last_o}, int'(ev));
    check_int("round", int'(round_o), exp_round);
    check_int("onehot", int'($countones({init_o, sbox_o, shift_o, mix_o, ark_o}) <= 1), 1);
    if (done_o) begin
      last_done_e = e;
      if (done_q.size() == 0) check_int("done_unexpected", e, -1);
      else check_int("done_cycle", e, done_q.pop_front());
    end
    c_init  += int'(init_o);
    c_sbox  += int'(sbox_o);
    c_shift += int'(shift_o);
    c_mix   += int'(mix_o);
    c_ark   += int'(ark_o);
    if (init_o) dp = 128'h00112233445566778899aabbccddeeff ^ rk[0];
    if (sbox_o) dp = sub_bytes(dp);
    if (shift_o) dp = shift_rows(dp);
    if (mix_o) dp = mix_columns(dp);
    if (ark_o && round_o <= 4'd10) dp = dp ^ rk[round_o];
  endtask

  vec_t vecs[4];
  int   base;
  int   dones[$];

  initial begin
    vecs[0] = '{2'b00, 41, 10, 10, 9, 10};
    vecs[1] = '{2'b01, 49, 12, 12, 11, 12};
    vecs[2] = '{2'b10, 57, 14, 14, 13, 14};
    vecs[3] = '{2'b11, 41, 10, 10, 9, 10};
    for (int i = 0; i < 256; i++) sb[i] = calc_sbox(8'(i));
    expand_key(128'h000102030405060708090a0b0c0d0e0f);
    dp = '0;

    rst_n = 1'b0;
    start = 1'b0;
    key_size = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_int("reset_outputs", {24'd0, busy_o, done_o, init_o, sbox_o, shift_o, mix_o, ark_o,
              last_o}, 0);
    check_int("reset_round", int'(round_o), 0);
    #2 rst_n = 1'b1;
    repeat (3) tick();

    foreach (vecs[k]) begin
      c_init = 0; c_sbox = 0; c_shift = 0; c_mix = 0; c_ark = 0;
      dp = '0;
      key_size = vecs[k].ks;
      start = 1'b1;
      base = edge_cnt;
      tick();
      start = 1'b0;
      key_size = ~vecs[k].ks;
      repeat (62) tick();
      check_int($sformatf("v%0d_done_t", k), last_done_e - base + 1, vecs[k].done_t);
      check_int($sformatf("v%0d_init", k), c_init, 1);
      check_int($sformatf("v%0d_sbox", k), c_sbox, vecs[k].n_sbox);
      check_int($sformatf("v%0d_shift", k), c_shift, vecs[k].n_shift);
      check_int($sformatf("v%0d_mix", k), c_mix, vecs[k].n_mix);
      check_int($sformatf("v%0d_ark", k), c_ark, vecs[k].n_ark);
      if (vecs[k].done_t == 41)
        check_blk($sformatf("v%0d_ciphertext", k), dp, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    end

    // start held high; key_size wiggles mid-block but is 00 at every acceptance edge
    base = edge_cnt;
    for (int i = 0; i < 200; i++) begin
      start = 1'b1;
      key_size = ((i % 42) >= 10 && (i % 42) < 30) ? 2'b10 : 2'b00;
      tick();
      if (done_o) dones.push_back(edge_cnt - base);
    end
    start = 1'b0;
    key_size = 2'b00;
    repeat (50) tick();
    check_int("hold_done_count", dones.size(), 4);
    for (int i = 0; i < 4; i++)
      check_int($sformatf("hold_done_%0d", i), (i < dones.size()) ? dones[i] : -1, 41 + 42*i);

    // asynchronous reset in the middle of round 5 MIX
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    check_int("pre_reset_mix", {31'd0, mix_o}, 1);
    check_int("pre_reset_round", int'(round_o), 5);
    #2 rst_n = 1'b0;
    #1;
    check_int("async_reset_outputs", {24'd0, busy_o, done_o, init_o, sbox_o, shift_o, mix_o,
              ark_o, last_o}, 0);
    check_int("async_reset_round", int'(round_o), 0);
    m_act = 0;
    done_q.delete();
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (30) tick();
    start = 1'b1;
    base = edge_cnt;
    tick();
    start = 1'b0;
    repeat (45) tick();
    check_int("post_reset_done_t", last_done_e - base + 1, 41);
    check_int("scoreboard_empty", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the AES encryption datapath. It accepts a start request and latches the key size. It then drives the stage enables for SubBytes (`Sboxall`), ShiftRows, MixColumns and AddRoundKey one step per clock, for the number of rounds the key size requires. It also outputs the current round index for round-key selection and signals completion with a one-cycle `done` pulse.

## Interface

- `NR_W`, default 4: width of the round-index output; must hold 0..14.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request to encrypt the block currently presented to the datapath; sampled only in IDLE.
- `key_size` input 2: 00 = 128-bit (Nr=10), 01 = 192-bit (Nr=12), 10 = 256-bit (Nr=14), 11 = treated as 128-bit; latched when `start` is accepted.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse; the datapath output register holds the ciphertext.
- `init_ark_en` output 1: initial AddRoundKey (plaintext XOR round key 0).
- `sbox_en` output 1: SubBytes step enable.
- `shiftrows_en` output 1: ShiftRows step enable.
- `mixcolumns_en` output 1: MixColumns step enable.
- `addrndkey_en` output 1: round AddRoundKey step enable.
- `round` output NR_W: current round index, 0..Nr.
- `last_round` output 1: high while `round == Nr`.

## Operation

- States: IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, DONE.
- Outputs are Moore outputs decoded from registered state. At most one of the five step enables is high in any cycle.
- IDLE:
  - `start=1` latches Nr from `key_size` (11 → 10), sets `round=0` and moves to INIT_ARK.
  - `start=0` stays in IDLE.
- INIT_ARK: `init_ark_en=1`. Next state is SUB, with `round` incremented to 1.
- SUB: `sbox_en=1`, then SHIFT.
- SHIFT: `shiftrows_en=1`. Next state is ARK if `round == Nr`, else MIX.
- MIX: `mixcolumns_en=1`, then ARK. MIX is never entered in the final round.
- ARK: `addrndkey_en=1`.
  - If `round == Nr`, go to DONE and hold `round`.
  - Otherwise go to SUB and increment `round`.
- DONE: `done=1` and `busy=1`; `round` holds Nr. Unconditional transition to IDLE.
- In IDLE, `round` returns to 0.
- `start` is ignored in every non-IDLE state, including DONE. It is not queued.
- A `key_size` change after acceptance has no effect until the next accepted start.
- Round counter never exceeds Nr and never wraps. Any unused state encoding recovers to IDLE on the next edge.
- `rst_n` low at any time, including mid-round:
  - Forces IDLE immediately.
  - All outputs go to 0: `busy`, `done`, all enables, `round`, `last_round`.
  - Latched Nr resets to 10.
  - No `done` is produced for the aborted block.

## Timing

- Cycle 0 is the edge at which `start` is sampled in IDLE. Step cycles are numbered from there.
- Cycle 1: INIT_ARK.
- Rounds 1..Nr-1: 4 cycles each (SUB, SHIFT, MIX, ARK).
- Round Nr: 3 cycles (SUB, SHIFT, ARK).
- Last ARK falls on cycle 4·Nr. `done` is high on cycle 4·Nr+1: cycle 41 for 128-bit, 49 for 192-bit, 57 for 256-bit.
- `busy` is high on cycles 1 through 4·Nr+1 inclusive.
- The earliest accepted next `start` is sampled at the edge ending the DONE cycle's successor (IDLE). Back-to-back throughput is 4·Nr+2 cycles per block.
- The `round` value during SUB, SHIFT, MIX and ARK of round r equals r. Round-key index r is valid in the same cycle as `addrndkey_en`.

## Test plan

- key_size=00 with a 1-cycle start pulse:
  - `init_ark_en` on cycle 1; `done` only on cycle 41.
  - Exactly 10 `sbox_en`, 10 `shiftrows_en`, 9 `mixcolumns_en` and 10 `addrndkey_en` pulses.
  - `round` runs 0→10.
  - On FIPS-197 vector 000102..0f / 00112233..ff, datapath out = 69c4e0d8..c55a.
- key_size=01 and key_size=10:
  - `done` on cycles 49 and 57 respectively.
  - `mixcolumns_en` counts 11 and 13.
  - `last_round` high only during the final SUB/SHIFT/ARK and DONE.
- key_size=11: behaviour identical to 00, with `done` on cycle 41.
- `start` held high continuously for 200 cycles with key_size=00:
  - `done` on cycles 41, 83, 125 and 167.
  - No start accepted while `busy`.
  - Changing `key_size` mid-block does not alter the block length.
- `rst_n` asserted asynchronously mid-cycle during round 5 MIX:
  - All outputs are 0 before the next clock edge.
  - No `done` appears.
  - A fresh start after release completes in 41 cycles.
- One-hot check over all runs: no two step enables are ever high in the same cycle, and `round` never exceeds Nr.
